fc_input_buffer: RTL
====================

# fc_input_buffer

Single-frame activation buffer between the last conv/pool stage and the fully-connected layer. It accepts a streamed feature vector of `DEPTH` words from the upstream stage through a valid/ready handshake. Once the frame is complete it pulses `start` to the dense layer. It then serves that layer's synchronous-read port (`in_addr` / `in_en` / `in_q`) until the dense layer's `done` releases it for the next frame.

## Interface
Parameters:
- `DATA_WIDTH`, 16 — signed activation width.
- `DEPTH`, 1568 — words per frame (dense `IN_DIM`).
- `AW`, `(DEPTH<=1)?1:$clog2(DEPTH)` — derived address width; do not override.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `wr_valid`  in  1  — upstream word valid.
- `wr_data`  in  DATA_WIDTH signed  — upstream word.
- `wr_ready`  out  1  — buffer accepts a word this cycle.
- `start`  out  1  — one-cycle pulse to the dense layer: frame complete.
- `in_addr`  in  AW  — read address from the dense layer.
- `in_en`  in  1  — read enable from the dense layer; used for bounds checking only.
- `in_q`  out  DATA_WIDTH signed  — registered read data.
- `done`  in  1  — dense layer finished; release the frame.
- `busy`  out  1  — frame held for the consumer (START or HOLD).
- `frames`  out  16  — count of released frames, wraps at 16'hFFFF→0.
- `rd_err`  out  1  — sticky out-of-range read flag (see Configuration).

## Operation
- Storage: `DEPTH` × `DATA_WIDTH` array, inferred as block RAM.
- Storage ports: one write port, one read port. Contents are not cleared by reset.

States:
- FILL (reset state):
  - `wr_ready`=1.
  - On `wr_valid && wr_ready`, write `mem[wr_ptr] <= wr_data`.
  - If `wr_ptr==DEPTH-1`, clear `wr_ptr` and go to START; otherwise increment `wr_ptr`.
- START:
  - `start`=1 for exactly this cycle; `wr_ready`=0.
  - Always advance to HOLD.
- HOLD:
  - `wr_ready`=0.
  - On `done`=1: go to FILL, `frames <= frames+1`, `wr_ptr` stays 0.

Other rules:
- `done` in FILL or START is ignored.
- `wr_valid` while `wr_ready`=0 is ignored; nothing is written.
- `wr_ready` and `busy` decode the state register combinationally (Moore); `start` is the same.

Read port:
- `in_q <= mem[in_addr]` on every rising edge, in every state, independent of `in_en`.
- This matches the dense layer, which presents the address one cycle before it consumes `in_q`.
- Same-address read and write in one cycle is read-first: `in_q` returns the old word.
- Reads during FILL are legal and have no side effects.

Reset values (asynchronous assertion):
- state=FILL, `wr_ptr`=0.
- `wr_ready`=1, `start`=0, `busy`=0.
- `in_q`=0, `frames`=0, `rd_err`=0.

Reset mid-frame discards the partial frame; the next accepted word lands at address 0.

## Timing
- Write acceptance is sampled at the edge where `wr_valid && wr_ready`.
- After the last word is accepted at edge N:
  - state is START during cycle N+1 (`start`=1, `wr_ready`=0);
  - state is HOLD from cycle N+2.
- Read latency: address at edge K yields `in_q` valid after edge K+1, i.e. 1 cycle.
- Release: `done` sampled at edge M → FILL with `wr_ready`=1 from cycle M+1, and `frames` updated at edge M.
- Minimum frame turnaround: `DEPTH` + 2 cycles plus consumer time.
- No combinational path from any input to any output.

## Configuration
Macro: `FIB_BOUNDS_CHECK_EN`.

Defined:
- A read with `in_en`=1 and `in_addr >= DEPTH` loads `in_q <= 0` instead of memory.
- The same read sets `rd_err`.
- `rd_err` clears only on reset.

Undefined:
- No check; `in_q <= mem[in_addr]` unconditionally.
- `rd_err` is tied to 0.

## Test plan
- Reset, then stream words 0..DEPTH-1 with `wr_data`=index and `wr_valid` held high:
  - `wr_ready` drops the cycle after the last word;
  - `start` is high for exactly one cycle;
  - `busy`=1.
- Read back in HOLD with `in_addr`=0, 5, DEPTH-1: `in_q`=0, 5, DEPTH-1, each one cycle later.
- In HOLD, drive `wr_valid`=1 with `wr_data`=16'h7FFF: memory is unchanged (readback of address 0 stays 0), and there is no second `start`.
- Pulse `done` in START: ignored, state stays HOLD. Then pulse `done` in HOLD: `frames`=1, `wr_ready`=1 next cycle, and the next word writes address 0.
- Assert `reset_n`=0 after 100 of DEPTH words, release, then stream a full frame of 16'h8000: `start` fires only after DEPTH new words, and every readback is 16'h8000.
- With `FIB_BOUNDS_CHECK_EN`, read `in_addr`=DEPTH (when representable) with `in_en`=1: `in_q`=0 and `rd_err`=1, and `rd_err` stays set across a following frame.

Source files
------------

// File: rtl/fc_input_buffer.sv
// Single-frame activation buffer feeding the dense layer: FILL -> START -> HOLD.
// Optional out-of-range read checking is enabled by defining FIB_BOUNDS_CHECK_EN.
module fc_input_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1568,
  parameter int AW         = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         wr_ready,
  output logic                         start,
  input  logic        [AW-1:0]         in_addr,
  input  logic                         in_en,
  output logic signed [DATA_WIDTH-1:0] in_q,
  input  logic                         done,
  output logic                         busy,
  output logic        [15:0]           frames,
  output logic                         rd_err
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t                 state_r;
  logic [AW-1:0]          wr_ptr_r;
  logic [15:0]            frames_r;
  logic [DATA_WIDTH-1:0]  in_q_r;
  logic                   rd_err_r;
  logic                   wr_en_s;
  logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];

  assign wr_en_s = wr_valid && (state_r == FILL);

  // Frame sequencing: write pointer, state and released-frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= FILL;
      wr_ptr_r <= '0;
      frames_r <= 16'd0;
    end else begin
      case (state_r)
        FILL: begin
          if (wr_valid) begin
            if (wr_ptr_r == LAST_PTR) begin
              wr_ptr_r <= '0;
              state_r  <= START;
            end else begin
              wr_ptr_r <= wr_ptr_r + AW'(1);
            end
          end
        end
        START: state_r <= HOLD;
        HOLD: begin
          if (done) begin
            state_r  <= FILL;
            frames_r <= frames_r + 16'd1;
          end
        end
        default: begin
          state_r  <= FILL;
          wr_ptr_r <= '0;
        end
      endcase
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

`ifdef FIB_BOUNDS_CHECK_EN
  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);
  logic oob_s;
  assign oob_s = in_en && ({1'b0, in_addr} >= DEPTH_X);

  // Registered read port with out-of-range substitution and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q_r   <= '0;
      rd_err_r <= 1'b0;
    end else if (oob_s) begin
      in_q_r   <= '0;
      rd_err_r <= 1'b1;
    end else begin
      in_q_r   <= mem[in_addr];
      rd_err_r <= rd_err_r;
    end
  end
`else
  logic unused_in_en_s;
  assign unused_in_en_s = in_en;

  // Registered read port; read-first against a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q_r <= '0;
    end else begin
      in_q_r <= mem[in_addr];
    end
  end

  assign rd_err_r = 1'b0;
`endif

  // Moore decode of the state register.
  always_comb begin
    wr_ready = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    case (state_r)
      FILL:  wr_ready = 1'b1;
      START: begin
        start = 1'b1;
        busy  = 1'b1;
      end
      HOLD:  busy = 1'b1;
      default: wr_ready = 1'b0;
    endcase
  end

  assign in_q   = in_q_r;
  assign frames = frames_r;
  assign rd_err = rd_err_r;

endmodule
